display_scanner: RTL and testbench
==================================

# display_scanner

Time-multiplexed scan controller for an N-digit common-anode seven-segment display. It holds a multi-digit hex value and walks the digits one at a time. For each digit it presents a nibble and a decimal-point flag to the downstream `display` decoder and drives the matching active-low anode. A guard interval is inserted between digits to suppress ghosting. New values are latched on a strobe and applied only at frame boundaries, so a frame never shows a mix of old and new digits.

## Interface
- `DIGITS`, 4: number of digits, legal range 2..8.
- `SLOT_CYCLES`, 50000: clock cycles per digit slot, guard included; must be greater than `GUARD_CYCLES`.
- `GUARD_CYCLES`, 500: cycles at the start of each slot with all anodes off; minimum 1.
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: scan enable, level-sensitive.
- `load` in 1: single-cycle strobe that captures `value`, `dp_mask` and `blank_lz`.
- `value` in 4*DIGITS: hex digits; index 0 = `value[3:0]` = rightmost digit.
- `dp_mask` in DIGITS: decimal point request per digit; 1 = lit.
- `blank_lz` in 1: enable leading-zero blanking.
- `digit` out 4: nibble for the decoder.
- `dp` out 1: decimal-point flag for the decoder; 1 = lit.
- `anode_n` out DIGITS: active-low digit select.
- `frame_start` out 1: one-cycle pulse on entry to the index-0 guard.

## Operation
- Register sets:
  - pending set `{value, dp_mask, blank_lz}` is written on any cycle with `load`=1;
  - active set is copied from pending on entry to the index-0 guard;
  - if `load` coincides with that entry, the incoming inputs are copied directly to active (bypass).
- States:
  - `OFF`: all anodes off; `index`=0; slot counter `cnt`=0.
  - `GUARD`: all anodes off; `digit` and `dp` already show the current index.
  - `ON`: `anode_n[index]`=0, unless the digit is blanked.
- Transitions:
  - `OFF` goes to `GUARD` when `en`=1; `index`=0 and `frame_start` pulses.
  - `GUARD` goes to `ON` when `cnt`=`GUARD_CYCLES`-1.
  - `ON` goes to `GUARD` when `cnt`=`SLOT_CYCLES`-1. `index` increments, wrapping from `DIGITS`-1 to 0; the wrap asserts `frame_start` and triggers the active-set copy.
  - Any state goes to `OFF` on the cycle after `en` is sampled 0.
- `cnt` counts 0..`SLOT_CYCLES`-1 across one slot and clears on each slot entry. Its width is `$clog2(SLOT_CYCLES)`.
- Leading-zero blanking: digit i is blanked when all of the following hold in the active set:
  - `blank_lz`=1;
  - i≠0;
  - every nibble at indices i..`DIGITS`-1 is 0;
  - `dp_mask[i]`=0.

  A blanked digit keeps its anode high through its `ON` slot. Digit 0 is never blanked.
- `digit` = active nibble[index]; `dp` = active `dp_mask[index]`.

## Timing
- Reset values: `digit`=0, `dp`=0, `anode_n`=all ones, `frame_start`=0, state `OFF`, `index`=0, `cnt`=0, pending and active sets all zero.
- All outputs are registered; no combinational path from inputs to outputs.
- `en` sampled 1 at edge t: `GUARD` from t+1 with `frame_start`=1 during cycle t+1; `anode_n[0]` goes low at t+1+`GUARD_CYCLES`.
- Slot length is exactly `SLOT_CYCLES`; frame period is `DIGITS`*`SLOT_CYCLES`.
- `digit` and `dp` change only at `GUARD` entry and are stable for the whole slot.
- `load` during a frame does not affect that frame; it takes effect at the next index-0 guard.
- Multiple `load` strobes within one frame: the last one wins.
- `en` deasserted mid-slot: `anode_n`=all ones on the next cycle. Pending data is retained; re-enable restarts at index 0 with a fresh guard.
- Reset mid-operation: outputs return to reset values immediately, asynchronously.

## Structure
- Package `display_pkg`:
  - `MAX_DIGITS`=8;
  - scan-state enum `{OFF, GUARD, ON}`;
  - `NIBBLE_W`=4.
- Sub-module `scan_slot_timer`: owns `cnt` and emits `guard_done` and `slot_done` pulses.
- The leading-zero mask is combinational logic inside `display_scanner`.
- The segment decoder is a separate downstream instance, not instantiated here.

## Test plan
All scenarios use `DIGITS`=4, `SLOT_CYCLES`=8, `GUARD_CYCLES`=2.
- Reset, then `en`=1 with no load: `digit`=0 and `frame_start` pulses once per 32 cycles. `anode_n` sequence is 1111×2, 1110×6, 1111×2, 1101×6, and so on.
- `load` `value`=0x1234, `dp_mask`=0b0100, then `en`=1: the frame shows digits 4,3,2,1. `dp`=1 only during the index-2 slot.
- `load` 0x0007 with `blank_lz`=1: only `anode_n[0]` ever goes low. With `dp_mask`=0b0010 added, index 1 also lights, showing `digit`=0 with `dp`=1.
- Mid-frame `load` 0xBEEF while 0x1234 is displayed: the remaining slots of the current frame still show 0x1234. 0xBEEF appears from the next `frame_start`.
- `load` coincident with a `frame_start` cycle: the new value is displayed in that same frame.
- `en` dropped during an `ON` slot, then `rst_n` pulsed low mid-slot: `anode_n`=1111 the next cycle after `en`=0, and immediately on reset. After re-enable, `frame_start` pulses and scanning restarts at index 0.

Source files
------------

// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared constants and scan-state type for the display scanner
package display_pkg;

    localparam int MAX_DIGITS = 8;
    localparam int NIBBLE_W   = 4;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        GUARD = 2'd1,
        ON    = 2'd2
    } scan_state_e;

endpackage

// File: rtl/scan_slot_timer.sv
// rtl/scan_slot_timer.sv - per-slot cycle counter with guard/slot end decodes
module scan_slot_timer #(
    parameter int SLOT_CYCLES  = 50000,
    parameter int GUARD_CYCLES = 500,
    localparam int CNT_W       = $clog2(SLOT_CYCLES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             run_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             guard_done_o,
    output logic             slot_done_o
);

    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SLOT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear wins over counting so every slot entry starts from zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (run_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o        = cnt_q;
    assign guard_done_o = (cnt_q == GUARD_LAST);
    assign slot_done_o  = (cnt_q == SLOT_LAST);

endmodule

// File: rtl/display_scanner.sv
// rtl/display_scanner.sv - time-multiplexed seven-segment digit scan controller
module display_scanner
    import display_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int SLOT_CYCLES  = 50000,
    parameter int GUARD_CYCLES = 500
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic                         load,
    input  logic [NIBBLE_W*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]            dp_mask,
    input  logic                         blank_lz,
    output logic [NIBBLE_W-1:0]          digit,
    output logic                         dp,
    output logic [DIGITS-1:0]            anode_n,
    output logic                         frame_start
);

    localparam int IDX_W = $clog2(DIGITS);
    localparam int CNT_W = $clog2(SLOT_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    scan_state_e state_q, state_d;
    logic [IDX_W-1:0] index_q, index_d;

    logic [NIBBLE_W*DIGITS-1:0] pend_value_q, act_value_q, act_value_d;
    logic [DIGITS-1:0]          pend_dp_q, act_dp_q, act_dp_d;
    logic                       pend_blz_q, act_blz_q, act_blz_d;

    logic [NIBBLE_W-1:0] digit_q, digit_d;
    logic                dp_q, dp_d;
    logic [DIGITS-1:0]   anode_n_q, anode_n_d;
    logic                frame_start_q, frame_start_d;

    logic slot_entry;
    logic frame_entry;
    logic timer_run;
    logic timer_clr;
    logic guard_done;
    logic slot_done;
    logic [CNT_W-1:0] cnt;

    logic [NIBBLE_W-1:0] act_nib_d [DIGITS];
    logic [DIGITS-1:0]   blank_mask;
    logic                zero_above;

    scan_slot_timer #(
        .SLOT_CYCLES  (SLOT_CYCLES),
        .GUARD_CYCLES (GUARD_CYCLES)
    ) u_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr_i        (timer_clr),
        .run_i        (timer_run),
        .cnt_o        (cnt),
        .guard_done_o (guard_done),
        .slot_done_o  (slot_done)
    );

    // Scan sequencing: OFF -> GUARD -> ON -> GUARD ..., with en low forcing OFF.
    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        slot_entry  = 1'b0;
        frame_entry = 1'b0;
        timer_run   = 1'b0;
        case (state_q)
            OFF: begin
                if (en) begin
                    state_d     = GUARD;
                    index_d     = '0;
                    slot_entry  = 1'b1;
                    frame_entry = 1'b1;
                end
            end
            GUARD: begin
                timer_run = 1'b1;
                if (guard_done) begin
                    state_d = ON;
                end
            end
            ON: begin
                timer_run = 1'b1;
                if (slot_done) begin
                    state_d    = GUARD;
                    slot_entry = 1'b1;
                    if (index_q == IDX_LAST) begin
                        index_d     = '0;
                        frame_entry = 1'b1;
                    end else begin
                        index_d = index_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = OFF;
                index_d = '0;
            end
        endcase
        if (!en) begin
            state_d     = OFF;
            index_d     = '0;
            slot_entry  = 1'b0;
            frame_entry = 1'b0;
            timer_run   = 1'b0;
        end
    end

    assign timer_clr = slot_entry | (state_d == OFF);

    // Active set refresh at each frame start; a coincident load bypasses pending.
    always_comb begin
        act_value_d = act_value_q;
        act_dp_d    = act_dp_q;
        act_blz_d   = act_blz_q;
        if (frame_entry) begin
            if (load) begin
                act_value_d = value;
                act_dp_d    = dp_mask;
                act_blz_d   = blank_lz;
            end else begin
                act_value_d = pend_value_q;
                act_dp_d    = pend_dp_q;
                act_blz_d   = pend_blz_q;
            end
        end
    end

    // Split the next active value into per-digit nibbles for indexing.
    always_comb begin
        for (int i = 0; i < DIGITS; i++) begin
            act_nib_d[i] = act_value_d[i*NIBBLE_W +: NIBBLE_W];
        end
    end

    // Leading-zero mask: walk from the top digit down while every nibble seen is zero.
    always_comb begin
        blank_mask = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above    = zero_above & (act_value_q[i*NIBBLE_W +: NIBBLE_W] == '0);
            blank_mask[i] = act_blz_q & zero_above & ~act_dp_q[i];
        end
    end

    // Output next-state: digit/dp only move at slot entry, anodes follow the next state.
    always_comb begin
        digit_d       = digit_q;
        dp_d          = dp_q;
        anode_n_d     = '1;
        frame_start_d = frame_entry;
        if (slot_entry) begin
            digit_d = act_nib_d[index_d];
            dp_d    = act_dp_d[index_d];
        end
        if (state_d == ON && !blank_mask[index_d]) begin
            anode_n_d[index_d] = 1'b0;
        end
    end

    // Scan state and digit index registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= OFF;
            index_q <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
        end
    end

    // Pending set captures every load strobe; the last one before a frame wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_value_q <= '0;
            pend_dp_q    <= '0;
            pend_blz_q   <= 1'b0;
        end else if (load) begin
            pend_value_q <= value;
            pend_dp_q    <= dp_mask;
            pend_blz_q   <= blank_lz;
        end
    end

    // Active set registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_value_q <= '0;
            act_dp_q    <= '0;
            act_blz_q   <= 1'b0;
        end else begin
            act_value_q <= act_value_d;
            act_dp_q    <= act_dp_d;
            act_blz_q   <= act_blz_d;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_q       <= '0;
            dp_q          <= 1'b0;
            anode_n_q     <= '1;
            frame_start_q <= 1'b0;
        end else begin
            digit_q       <= digit_d;
            dp_q          <= dp_d;
            anode_n_q     <= anode_n_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign digit       = digit_q;
    assign dp          = dp_q;
    assign anode_n     = anode_n_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_display_scanner.sv
// tb/tb_display_scanner.sv - randomized and directed bench with a frame-arithmetic reference model
module tb_display_scanner;

    localparam int D = 4;
    localparam int S = 8;
    localparam int G = 2;
    localparam int FRAME = D * S;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_mask;
    logic        blank_lz;
    logic [3:0]  digit;
    logic        dp;
    logic [3:0]  anode_n;
    logic        frame_start;

    int checks;
    int errors;

    // reference model state
    logic [15:0] pv, av;
    logic [3:0]  pd, ad;
    logic        pb, ab;
    bit          running;
    int          k;
    logic [3:0]  e_digit;
    logic        e_dp;
    logic [3:0]  e_an;
    logic        e_fs;

    display_scanner #(
        .DIGITS       (D),
        .SLOT_CYCLES  (S),
        .GUARD_CYCLES (G)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .load        (load),
        .value       (value),
        .dp_mask     (dp_mask),
        .blank_lz    (blank_lz),
        .digit       (digit),
        .dp          (dp),
        .anode_n     (anode_n),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit blanked(int i);
        return ab && (i != 0) && ((av >> (4 * i)) == 16'd0) && !ad[i];
    endfunction

    task automatic model_reset();
        pv = '0; av = '0; pd = '0; ad = '0; pb = 1'b0; ab = 1'b0;
        running = 0; k = 0;
        e_digit = '0; e_dp = 1'b0; e_an = 4'hF; e_fs = 1'b0;
    endtask

    // Advance the model by one clock using the inputs sampled at that edge.
    task automatic model_step();
        int idx;
        int pos;
        bit frame;
        if (!en) begin
            running = 0;
        end else if (!running) begin
            running = 1;
            k = 0;
        end else begin
            k = k + 1;
        end
        frame = running && (k % FRAME == 0);
        if (frame) begin
            if (load) begin av = value; ad = dp_mask; ab = blank_lz; end
            else      begin av = pv;    ad = pd;      ab = pb;       end
        end
        if (load) begin pv = value; pd = dp_mask; pb = blank_lz; end
        e_an = 4'hF;
        e_fs = 1'b0;
        if (running) begin
            idx     = (k / S) % D;
            pos     = k % S;
            e_fs    = frame;
            e_digit = 4'((av >> (4 * idx)) & 16'hF);
            e_dp    = ad[idx];
            if (pos >= G && !blanked(idx)) e_an[idx] = 1'b0;
        end
    endtask

    task automatic check_outputs();
        checks++;
        assert (anode_n === e_an) else begin
            errors++; $error("FAIL anode_n got %b exp %b t=%0t", anode_n, e_an, $time);
        end
        checks++;
        assert (digit === e_digit) else begin
            errors++; $error("FAIL digit got %h exp %h t=%0t", digit, e_digit, $time);
        end
        checks++;
        assert (dp === e_dp) else begin
            errors++; $error("FAIL dp got %b exp %b t=%0t", dp, e_dp, $time);
        end
        checks++;
        assert (frame_start === e_fs) else begin
            errors++; $error("FAIL frame_start got %b exp %b t=%0t", frame_start, e_fs, $time);
        end
    endtask

    task automatic cycle(input logic en_v, input logic load_v, input logic [15:0] val_v,
                         input logic [3:0] dpm_v, input logic blz_v);
        en = en_v; load = load_v; value = val_v; dp_mask = dpm_v; blank_lz = blz_v;
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0; en = 1'b0; load = 1'b0; value = '0; dp_mask = '0; blank_lz = 1'b0;
        model_reset();

        // reset values
        cycle(1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
        cycle(1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
        #2 rst_n = 1'b1;

        // free run with no load: digit 0, frame_start every 32 cycles
        run(70);

        // 0x1234 with dp on index 2
        cycle(1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
        cycle(1'b0, 1'b1, 16'h1234, 4'b0100, 1'b0);
        run(40);

        // leading-zero blanking, then dp keeps index 1 lit
        cycle(1'b0, 1'b1, 16'h0007, 4'b0000, 1'b1);
        run(35);
        cycle(1'b0, 1'b1, 16'h0007, 4'b0010, 1'b1);
        run(40);

        // mid-frame load must wait for the next frame
        cycle(1'b0, 1'b1, 16'h1234, 4'b0000, 1'b0);
        run(10);
        cycle(1'b1, 1'b1, 16'hBEEF, 4'b0000, 1'b0);
        run(60);

        // load coinciding with frame entry is shown in that frame (bounded wait)
        for (int i = 0; i < FRAME && !(running && (k % FRAME == FRAME - 1)); i++) run(1);
        cycle(1'b1, 1'b1, 16'hA5C3, 4'b1001, 1'b0);
        run(34);

        // randomized loads and enable drops
        for (int i = 0; i < 800; i++) begin
            cycle(($urandom_range(0, 49) != 0), ($urandom_range(0, 19) == 0),
                  16'($urandom_range(0, 65535)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)));
        end
        cycle(1'b1, 1'b1, 16'h0030, 4'b0000, 1'b1);
        run(70);

        // en dropped in an ON slot
        for (int i = 0; i < S && !(running && (k % S >= G + 1)); i++) run(1);
        cycle(1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
        run(13);

        // asynchronous reset mid-slot
        #2 rst_n = 1'b0;
        #1;
        checks++;
        assert (anode_n === 4'hF) else begin
            errors++; $error("FAIL async_rst_anode got %b exp %b", anode_n, 4'hF);
        end
        checks++;
        assert (digit === 4'h0 && dp === 1'b0 && frame_start === 1'b0) else begin
            errors++; $error("FAIL async_rst_outs got %h/%b/%b exp 0/0/0", digit, dp, frame_start);
        end
        model_reset();
        cycle(1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
        #2 rst_n = 1'b1;
        run(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
